// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned WIDTH x WIDTH shift-add multiplier for the execute stage.
// One partial product per cycle is accumulated through a 64-bit hybrid adder.

// 4-bit carry-lookahead block: the carry inside the block is computed in parallel.
module cla_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// 64-bit hybrid adder: lookahead inside each 4-bit block, ripple between blocks.
module hybrid_adder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[16];

  for (genvar i = 0; i < 16; i++) begin : g_blk
    cla_4 u_cla (
      .a    (a[4*i +: 4]),
      .b    (b[4*i +: 4]),
      .cin  (carry[i]),
      .sum  (sum[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 32,  // only 32 matches the 64-bit adder
  parameter int CNT_W = 5    // 2**CNT_W must equal WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [PW-1:0]      mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [PW-1:0]      acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PW-1:0]      addend;
  logic [PW-1:0]      sum;
  logic               adder_cout_unused;  // cannot assert for a WIDTH x WIDTH product
  logic               last_iter;

  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  hybrid_adder_64 u_adder (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (adder_cout_unused)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are few and flat, so they are all reset; an abort leaves no stale partial state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      product  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          acc_q    <= sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // The previous product stays visible until the final sum is ready.
          if (last_iter) product <= sum;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table, scoreboard queue,
// and hand sequences for mid-run start, mid-run reset and held start.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  shift_add_multiplier #(.WIDTH(32), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          prev_done_cyc = 0;
  int          last_done_cyc = 0;
  logic [63:0] last_product = '0;
  logic [63:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with no outstanding request (cycle %0d)", cyc);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        check("product", product, exp);
        last_product = exp;
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, output int c0);
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    sb.push_back({32'b0, ia} * {32'b0, ib});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    c0    = cyc;
  endtask

  task automatic wait_done(input int c0, input string name);
    int nb;
    bit seen;
    nb   = 0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 100 cycles, expected done after 32", name);
    end else begin
      check({name, "_busy_cycles"}, 64'(nb), 64'd32);
      check({name, "_latency"}, 64'(cyc - c0), 64'd32);
      @(negedge clk);
      check({name, "_done_one_cycle"}, 64'(done), 64'd0);
      check({name, "_idle_busy"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    vec_t tbl[9];
    int   c0;
    int   base;
    int   nb;
    bit   injected;

    tbl[0] = '{32'd3,        32'd5,        64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'h1234_5678, 32'd0,        64'd0};
    tbl[3] = '{32'd0,        32'h9ABC_DEF0, 64'd0};
    tbl[4] = '{32'd1,        32'd1,        64'd1};
    tbl[5] = '{32'hFFFF_FFFF, 32'd1,        64'h0000_0000_FFFF_FFFF};
    tbl[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    for (int i = 7; i < 9; i++) begin
      tbl[i].a   = $urandom | 32'h1;
      tbl[i].b   = $urandom | 32'h1;
      tbl[i].exp = {32'b0, tbl[i].a} * {32'b0, tbl[i].b};
    end

    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table of operand pairs; the expected value is pushed in place of the operator model.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a     = tbl[i].a;
      b     = tbl[i].b;
      start = 1'b1;
      sb.push_back(tbl[i].exp);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      c0    = cyc;
      wait_done(c0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_product_held", i), product, tbl[i].exp);
    end

    // Start pulsed during RUN is dropped; old product holds while iterating.
    base     = done_cnt;
    injected = 1'b0;
    nb       = 0;
    issue(32'd7, 32'd6, c0);
    for (int k = 0; k < 100; k++) begin
      if (done) break;
      if (busy) nb++;
      if (nb == 10 && !injected) begin
        a        = 32'd2;
        b        = 32'd2;
        start    = 1'b1;
        injected = 1'b1;
        check("run_product_held", product, last_product);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("midstart_busy_cycles", 64'(nb), 64'd32);
    repeat (40) @(negedge clk);
    #1;
    check("midstart_single_done", 64'(done_cnt - base), 64'd1);
    check("midstart_product", product, 64'd42);
    check("midstart_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a cycle aborts the operation.
    issue(32'd100, 32'd200, c0);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    sb.delete();
    base = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    issue(32'd100, 32'd200, c0);
    wait_done(c0, "after_abort");
    check("after_abort_product", product, 64'd20000);

    // start held high: back-to-back ops every 34 cycles.
    @(negedge clk);
    a     = 32'h8000_0000;
    b     = 32'd2;
    start = 1'b1;
    sb.push_back(64'h0000_0001_0000_0000);
    sb.push_back(64'h0000_0001_0000_0000);
    base = done_cnt;
    @(posedge clk);
    @(negedge clk);
    c0 = cyc;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt == base + 2) break;
    end
    start = 1'b0;
    check("held_two_dones", 64'(done_cnt - base), 64'd2);
    check("held_first_latency", 64'(prev_done_cyc - c0), 64'd32);
    check("held_done_gap", 64'(last_done_cyc - prev_done_cyc), 64'd34);
    repeat (40) @(negedge clk);
    #1;
    check("held_no_third", 64'(done_cnt - base), 64'd2);
    check("held_product", product, 64'h0000_0001_0000_0000);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
